// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding control slice.
package cpu_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } hz_state_t;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // $0 is hard-wired, so a write to it never creates a dependency.
    function automatic logic reg_hit(input logic we, input logic [4:0] rd, input logic [4:0] rs);
        return we && (rd != REG_ZERO) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signals exchanged with the hazard controller; master is the pipeline.
interface hazard_if;

    logic [4:0] ID_Rs;
    logic [4:0] ID_Rt;
    logic       ID_UsesRt;
    logic [4:0] EX_Rs;
    logic [4:0] EX_Rt;
    logic [4:0] EX_Rd;
    logic       EX_RegWrite;
    logic       EX_MemRead;
    logic [4:0] MEM_Rd;
    logic       MEM_RegWrite;
    logic [4:0] WB_Rd;
    logic       WB_RegWrite;
    logic       EX_Redirect;

    logic       PCWrite;
    logic       IFID_Write;
    logic       IFID_Flush;
    logic       IDEX_Flush;
    logic [1:0] FwdA;
    logic [1:0] FwdB;

    modport master (
        output ID_Rs, ID_Rt, ID_UsesRt, EX_Rs, EX_Rt, EX_Rd, EX_RegWrite, EX_MemRead,
               MEM_Rd, MEM_RegWrite, WB_Rd, WB_RegWrite, EX_Redirect,
        input  PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, FwdA, FwdB
    );

    modport slave (
        input  ID_Rs, ID_Rt, ID_UsesRt, EX_Rs, EX_Rt, EX_Rd, EX_RegWrite, EX_MemRead,
               MEM_Rd, MEM_RegWrite, WB_Rd, WB_RegWrite, EX_Redirect,
        output PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, FwdA, FwdB
    );

endinterface

// File: rtl/fwd_unit.sv
// EX operand bypass select; compiled in only when HAZARD_FWD_EN is defined,
// otherwise both selects stay on the register file.
module fwd_unit
    import cpu_pkg::*;
(
    input  logic [4:0] ex_rs,
    input  logic [4:0] ex_rt,
    input  logic [4:0] mem_rd,
    input  logic       mem_we,
    input  logic [4:0] wb_rd,
    input  logic       wb_we,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

`ifdef HAZARD_FWD_EN
    // The younger EX/MEM result wins over MEM/WB when both match.
    function automatic logic [1:0] pick(input logic [4:0] rs, input logic [4:0] m_rd,
                                        input logic m_we, input logic [4:0] w_rd,
                                        input logic w_we);
        if (reg_hit(m_we, m_rd, rs))
            return FWD_EXMEM;
        else if (reg_hit(w_we, w_rd, rs))
            return FWD_MEMWB;
        else
            return FWD_RF;
    endfunction

    always_comb begin
        fwd_a = pick(ex_rs, mem_rd, mem_we, wb_rd, wb_we);
        fwd_b = pick(ex_rt, mem_rd, mem_we, wb_rd, wb_we);
    end
`else
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{ex_rs, ex_rt, mem_rd, mem_we, wb_rd, wb_we};

    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
    end
`endif

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush FSM and saturating performance counters for the 5-stage pipeline.
// HAZARD_FWD_EN selects the forwarding build (load-use only stalls).
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    hazard_if.slave          hz,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    hz_state_t  state, state_n;
    logic [1:0] stall_left, stall_left_n;
    logic [1:0] bubbles;
    logic       pc_write;
    logic [1:0] fwd_a, fwd_b;

    function automatic logic id_hit(input logic we, input logic [4:0] rd, input logic [4:0] rs,
                                    input logic [4:0] rt, input logic uses_rt);
        return reg_hit(we, rd, rs) || (uses_rt && reg_hit(we, rd, rt));
    endfunction

    // Bubbles the ID instruction needs before its operands are available.
    always_comb begin
        bubbles = 2'd0;
`ifdef HAZARD_FWD_EN
        if (id_hit(hz.EX_MemRead, hz.EX_Rd, hz.ID_Rs, hz.ID_Rt, hz.ID_UsesRt))
            bubbles = 2'd1;
`else
        if (id_hit(hz.EX_RegWrite, hz.EX_Rd, hz.ID_Rs, hz.ID_Rt, hz.ID_UsesRt))
            bubbles = 2'd2;
        else if (id_hit(hz.MEM_RegWrite, hz.MEM_Rd, hz.ID_Rs, hz.ID_Rt, hz.ID_UsesRt))
            bubbles = 2'd1;
`endif
    end

`ifdef HAZARD_FWD_EN
    logic unused_ex_we;
    assign unused_ex_we = hz.EX_RegWrite;
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= RUN;
            stall_left <= '0;
        end else begin
            state      <= state_n;
            stall_left <= stall_left_n;
        end
    end

    // A redirect squashes the instruction that would have been stalled.
    always_comb begin
        state_n      = state;
        stall_left_n = stall_left;
        unique case (state)
            RUN: begin
                if (!hz.EX_Redirect && bubbles != 2'd0) begin
                    stall_left_n = bubbles - 2'd1;
                    state_n      = (bubbles > 2'd1) ? STALL : RUN;
                end
            end
            STALL: begin
                if (hz.EX_Redirect) begin
                    state_n      = RUN;
                    stall_left_n = '0;
                end else begin
                    stall_left_n = (stall_left == 2'd0) ? 2'd0 : stall_left - 2'd1;
                    if (stall_left <= 2'd1)
                        state_n = RUN;
                end
            end
        endcase
    end

    always_comb begin
        pc_write      = 1'b1;
        hz.IFID_Write = 1'b1;
        hz.IFID_Flush = 1'b0;
        hz.IDEX_Flush = 1'b0;
        if (!Rst) begin
            if (hz.EX_Redirect) begin
                hz.IFID_Flush = 1'b1;
                hz.IDEX_Flush = 1'b1;
            end else if (state == STALL || bubbles != 2'd0) begin
                pc_write      = 1'b0;
                hz.IFID_Write = 1'b0;
                hz.IDEX_Flush = 1'b1;
            end
        end
    end

    assign hz.PCWrite = pc_write;

    fwd_unit u_fwd (
        .ex_rs  (hz.EX_Rs),
        .ex_rt  (hz.EX_Rt),
        .mem_rd (hz.MEM_Rd),
        .mem_we (hz.MEM_RegWrite),
        .wb_rd  (hz.WB_Rd),
        .wb_we  (hz.WB_RegWrite),
        .fwd_a  (fwd_a),
        .fwd_b  (fwd_b)
    );

    always_comb begin
        hz.FwdA = Rst ? FWD_RF : fwd_a;
        hz.FwdB = Rst ? FWD_RF : fwd_b;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (!pc_write && StallCount != '1)
                StallCount <= StallCount + CNT_W'(1);
            if (hz.EX_Redirect && FlushCount != '1)
                FlushCount <= FlushCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl against a bubble-count reference model.
module tb_hazard_ctrl;

`ifdef HAZARD_FWD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_if hif ();
    hazard_if hif2 ();

    logic [15:0] stall_cnt, flush_cnt;
    logic [1:0]  stall_cnt2, flush_cnt2;

    hazard_ctrl #(.CNT_W(16)) dut (
        .Clk(clk), .Rst(rst), .hz(hif), .StallCount(stall_cnt), .FlushCount(flush_cnt)
    );

    hazard_ctrl #(.CNT_W(2)) dut2 (
        .Clk(clk), .Rst(rst), .hz(hif2), .StallCount(stall_cnt2), .FlushCount(flush_cnt2)
    );

    assign hif2.ID_Rs        = hif.ID_Rs;
    assign hif2.ID_Rt        = hif.ID_Rt;
    assign hif2.ID_UsesRt    = hif.ID_UsesRt;
    assign hif2.EX_Rs        = hif.EX_Rs;
    assign hif2.EX_Rt        = hif.EX_Rt;
    assign hif2.EX_Rd        = hif.EX_Rd;
    assign hif2.EX_RegWrite  = hif.EX_RegWrite;
    assign hif2.EX_MemRead   = hif.EX_MemRead;
    assign hif2.MEM_Rd       = hif.MEM_Rd;
    assign hif2.MEM_RegWrite = hif.MEM_RegWrite;
    assign hif2.WB_Rd        = hif.WB_Rd;
    assign hif2.WB_RegWrite  = hif.WB_RegWrite;
    assign hif2.EX_Redirect  = hif.EX_Redirect;

    int tests = 0;
    int fails = 0;

    // Reference model: bubbles still owed plus raw event counts.
    int remaining = 0;
    int n_stall   = 0;
    int n_flush   = 0;
    int obs_stalls = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit hit(input bit we, input logic [4:0] rd);
        return we && rd != 5'd0 && (rd == hif.ID_Rs || (hif.ID_UsesRt && rd == hif.ID_Rt));
    endfunction

    function automatic int need_bubbles();
        if (FWD_ON)
            return hit(hif.EX_MemRead, hif.EX_Rd) ? 1 : 0;
        if (hit(hif.EX_RegWrite, hif.EX_Rd))
            return 2;
        if (hit(hif.MEM_RegWrite, hif.MEM_Rd))
            return 1;
        return 0;
    endfunction

    function automatic logic [1:0] fwd_of(input logic [4:0] r);
        if (!FWD_ON || rst || r == 5'd0)
            return 2'b00;
        if (hif.MEM_RegWrite && hif.MEM_Rd == r)
            return 2'b01;
        if (hif.WB_RegWrite && hif.WB_Rd == r)
            return 2'b10;
        return 2'b00;
    endfunction

    function automatic int sat(input int n, input int w);
        int top;
        top = (1 << w) - 1;
        return (n > top) ? top : n;
    endfunction

    task automatic clear_inputs();
        hif.ID_Rs = '0;  hif.ID_Rt = '0;  hif.ID_UsesRt = 1'b0;
        hif.EX_Rs = '0;  hif.EX_Rt = '0;  hif.EX_Rd = '0;
        hif.EX_RegWrite = 1'b0;  hif.EX_MemRead = 1'b0;
        hif.MEM_Rd = '0; hif.MEM_RegWrite = 1'b0;
        hif.WB_Rd = '0;  hif.WB_RegWrite = 1'b0;
        hif.EX_Redirect = 1'b0;
    endtask

    // One pipeline cycle: compare outputs mid-cycle, then advance the model across the edge.
    task automatic step(input string tag);
        bit stall_exp, redir;
        int need;
        @(negedge clk);
        need      = need_bubbles();
        redir     = hif.EX_Redirect;
        stall_exp = !rst && !redir && (remaining > 0 || need > 0);
        check($sformatf("%s.pcwrite", tag), hif.PCWrite, !stall_exp);
        check($sformatf("%s.ifid_write", tag), hif.IFID_Write, !stall_exp);
        check($sformatf("%s.ifid_flush", tag), hif.IFID_Flush, !rst && redir);
        check($sformatf("%s.idex_flush", tag), hif.IDEX_Flush, !rst && (redir || stall_exp));
        check($sformatf("%s.fwda", tag), hif.FwdA, fwd_of(hif.EX_Rs));
        check($sformatf("%s.fwdb", tag), hif.FwdB, fwd_of(hif.EX_Rt));
        check($sformatf("%s.stallcnt", tag), stall_cnt, sat(n_stall, 16));
        check($sformatf("%s.flushcnt", tag), flush_cnt, sat(n_flush, 16));
        check($sformatf("%s.stallcnt2", tag), stall_cnt2, sat(n_stall, 2));
        check($sformatf("%s.flushcnt2", tag), flush_cnt2, sat(n_flush, 2));
        if (!hif.PCWrite)
            obs_stalls++;
        if (rst) begin
            remaining = 0;
            n_stall   = 0;
            n_flush   = 0;
        end else begin
            if (stall_exp) n_stall++;
            if (redir) n_flush++;
            if (redir)
                remaining = 0;
            else if (remaining > 0)
                remaining--;
            else if (need > 0)
                remaining = need - 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        step("reset");
        step("reset");
        rst = 1'b0;
        obs_stalls = 0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1;
        do_reset();
        check("reset.stallcnt_zero", stall_cnt, 0);
        check("reset.flushcnt_zero", flush_cnt, 0);

        // $0 never causes a stall
        hif.EX_Rd = 5'd0; hif.EX_MemRead = 1'b1; hif.EX_RegWrite = 1'b1; hif.ID_Rs = 5'd0;
        step("zero_reg");
        clear_inputs();
        step("zero_reg_after");
        check("zero_reg.stalls", obs_stalls, 0);

        // EX producer read via Rt
        do_reset();
        hif.EX_Rd = 5'd10; hif.EX_RegWrite = 1'b1; hif.ID_Rt = 5'd10; hif.ID_UsesRt = 1'b1;
        step("ex_rt.c1");
        step("ex_rt.c2");
        clear_inputs();
        step("ex_rt.c3");
        check("ex_rt.stalls", obs_stalls, FWD_ON ? 0 : 2);
        check("ex_rt.stallcnt", stall_cnt, FWD_ON ? 0 : 2);

        // load-use
        do_reset();
        hif.EX_Rd = 5'd8; hif.EX_MemRead = 1'b1; hif.EX_RegWrite = 1'b1; hif.ID_Rs = 5'd8;
        step("load_use.c1");
        clear_inputs();
        step("load_use.c2");
        step("load_use.c3");
        check("load_use.stalls", obs_stalls, FWD_ON ? 1 : 2);
        check("load_use.stallcnt", stall_cnt, FWD_ON ? 1 : 2);

        // EX/MEM preferred over MEM/WB
        hif.MEM_Rd = 5'd9; hif.MEM_RegWrite = 1'b1; hif.EX_Rs = 5'd9;
        #1;
        check("fwd.exmem", hif.FwdA, FWD_ON ? 2'b01 : 2'b00);
        hif.WB_Rd = 5'd9; hif.WB_RegWrite = 1'b1;
        #1;
        check("fwd.exmem_over_wb", hif.FwdA, FWD_ON ? 2'b01 : 2'b00);
        hif.MEM_RegWrite = 1'b0;
        #1;
        check("fwd.memwb", hif.FwdA, FWD_ON ? 2'b10 : 2'b00);
        step("fwd");
        clear_inputs();

        // redirect beats a simultaneous load-use
        do_reset();
        hif.EX_Redirect = 1'b1;
        hif.EX_Rd = 5'd8; hif.EX_MemRead = 1'b1; hif.EX_RegWrite = 1'b1; hif.ID_Rs = 5'd8;
        #1;
        check("redirect.pcwrite", hif.PCWrite, 1);
        check("redirect.ifid_flush", hif.IFID_Flush, 1);
        check("redirect.idex_flush", hif.IDEX_Flush, 1);
        step("redirect.c1");
        clear_inputs();
        step("redirect.c2");
        check("redirect.stalls", obs_stalls, 0);
        check("redirect.flushcnt", flush_cnt, 1);
        check("redirect.stallcnt", stall_cnt, 0);

        // reset mid-stall
        do_reset();
        hif.EX_Rd = 5'd10; hif.EX_RegWrite = 1'b1; hif.EX_MemRead = 1'b1; hif.ID_Rs = 5'd10;
        step("rst_stall.c1");
        rst = 1'b1;
        step("rst_stall.c2");
        rst = 1'b0;
        clear_inputs();
        #1;
        check("rst_stall.pcwrite", hif.PCWrite, 1);
        check("rst_stall.stallcnt", stall_cnt, 0);
        check("rst_stall.flushcnt", flush_cnt, 0);
        step("rst_stall.c3");

        // saturation of the 2-bit counter
        do_reset();
        hif.EX_Rd = 5'd5; hif.EX_RegWrite = 1'b1; hif.EX_MemRead = 1'b1; hif.ID_Rs = 5'd5;
        for (int i = 0; i < 5; i++)
            step("sat");
        clear_inputs();
        step("sat.end");
        check("sat.stallcnt2", stall_cnt2, 3);
        check("sat.stallcnt", stall_cnt, FWD_ON ? 5 : 6);

        // random traffic on a small register set so matches are frequent
        for (int i = 0; i < 600; i++) begin
            rst              = ($urandom_range(63) == 0);
            hif.ID_Rs        = 5'($urandom_range(3));
            hif.ID_Rt        = 5'($urandom_range(3));
            hif.ID_UsesRt    = 1'($urandom_range(1));
            hif.EX_Rs        = 5'($urandom_range(3));
            hif.EX_Rt        = 5'($urandom_range(3));
            hif.EX_Rd        = 5'($urandom_range(3));
            hif.EX_MemRead   = 1'($urandom_range(1));
            hif.EX_RegWrite  = hif.EX_MemRead | 1'($urandom_range(1));
            hif.MEM_Rd       = 5'($urandom_range(3));
            hif.MEM_RegWrite = 1'($urandom_range(1));
            hif.WB_Rd        = 5'($urandom_range(3));
            hif.WB_RegWrite  = 1'($urandom_range(1));
            hif.EX_Redirect  = ($urandom_range(7) == 0);
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, width of the stall and flush performance counters.
REQ-002 Clk  input  1  pipeline clock (ClkOut domain), rising edge.
REQ-003 Rst  input  1  synchronous, active-high reset.
REQ-004 ID_Rs, ID_Rt  input  5 each  source register numbers of the instruction in IF/ID.
REQ-005 ID_UsesRt  input  1  ID instruction reads Rt as an operand.
REQ-006 EX_Rs, EX_Rt  input  5 each  source register numbers of the instruction in ID/EX.
REQ-007 EX_Rd, EX_RegWrite, EX_MemRead  input  5/1/1  destination, write enable and load flag of the instruction in ID/EX.
REQ-008 MEM_Rd, MEM_RegWrite  input  5/1  destination and write enable of the instruction in EX/MEM.
REQ-009 WB_Rd, WB_RegWrite  input  5/1  destination and write enable of the instruction in MEM/WB.
REQ-010 EX_Redirect  input  1  taken branch or jump resolved in EX this cycle.
REQ-011 PCWrite, IFID_Write  output  1 each  PC and IF/ID register load enables.
REQ-012 IFID_Flush, IDEX_Flush  output  1 each  insert a bubble into IF/ID or ID/EX.
REQ-013 FwdA, FwdB  output  2 each  EX operand select: 00 register file, 01 EX/MEM, 10 MEM/WB.
REQ-014 StallCount, FlushCount  output  CNT_W each  saturating performance counters.
REQ-015 Clock and reset are fixed as one clock, Clk, with a synchronous active-high reset, Rst.

Function
REQ-016 The FSM SHALL have the states RUN and STALL, plus a down-counter StallLeft[1:0].
REQ-017 Register $0 SHALL never produce a hazard or a forward.
REQ-018 A hazard SHALL be detected in RUN when ID_Rs, or ID_Rt with ID_UsesRt, matches the destination of a writing instruction in a later stage, as defined in REQ-030 and REQ-031.
REQ-019 In the detection cycle the block SHALL drive PCWrite=0, IFID_Write=0 and IDEX_Flush=1; it SHALL load StallLeft with the required bubbles minus one; it SHALL go to STALL when that value is nonzero.
REQ-020 In STALL the block SHALL hold PCWrite=0, IFID_Write=0 and IDEX_Flush=1 and decrement StallLeft; it SHALL return to RUN after the cycle in which StallLeft reaches 0. New detections SHALL be ignored while in STALL.
REQ-021 EX_Redirect=1 SHALL drive IFID_Flush=1 and IDEX_Flush=1 with PCWrite=1 in the same cycle, and SHALL take priority over a hazard detected in that cycle: no stall is entered and StallLeft is not loaded.
REQ-022 In RUN with no hazard and no redirect, the outputs SHALL be PCWrite=1, IFID_Write=1, IFID_Flush=0, IDEX_Flush=0.
REQ-023 StallCount SHALL increment on every cycle with PCWrite=0, and FlushCount SHALL increment on every cycle with EX_Redirect=1; both SHALL saturate at all-ones.
REQ-024 All control outputs SHALL be combinational from the state and the inputs; the state, StallLeft and the counters SHALL be registered.

Reset
REQ-025 When Rst=1 at a clock edge, the block SHALL enter RUN with StallLeft=0 and StallCount=FlushCount=0, aborting any stall in progress.
REQ-026 While Rst=1 the outputs SHALL be PCWrite=1, IFID_Write=1, IFID_Flush=0, IDEX_Flush=0 and FwdA=FwdB=00.

Configuration
REQ-027 The macro HAZARD_FWD_EN SHALL compile forwarding in.
REQ-028 With HAZARD_FWD_EN defined, FwdA and FwdB SHALL be computed from EX_Rs and EX_Rt respectively. EX/MEM SHALL be selected (01) over MEM/WB (10) when both stages match.
REQ-029 Without HAZARD_FWD_EN, FwdA and FwdB SHALL be tied to 00.
REQ-030 With HAZARD_FWD_EN, the only hazard SHALL be load-use (EX_MemRead and a match with EX_Rd), costing 1 bubble.
REQ-031 Without HAZARD_FWD_EN, a match with EX_Rd SHALL cost 2 bubbles and a match with MEM_Rd SHALL cost 1 bubble, with EX taking precedence. The register file writes in the first half of the cycle, so a WB match needs no stall.

Structure
REQ-032 The package cpu_pkg SHALL hold the FSM state typedef, the FWD_RF, FWD_EXMEM and FWD_MEMWB constants and the REG_ZERO constant.
REQ-033 A sub-module fwd_unit SHALL hold the forwarding comparators; hazard_ctrl SHALL hold the FSM and the counters.

Verification
REQ-034 Forwarding build, EX: lw $t0 with EX_Rd=8, EX_MemRead=1; ID_Rs=8 -> one cycle with PCWrite=0, IDEX_Flush=1, then RUN; StallCount=1.
REQ-035 Forwarding build, EX/MEM: MEM_Rd=9, MEM_RegWrite=1; EX_Rs=9 -> FwdA=01. Adding WB_Rd=9, WB_RegWrite=1 -> FwdA stays 01.
REQ-036 Non-forwarding build: EX_Rd=10, EX_RegWrite=1; ID_Rt=10, ID_UsesRt=1 -> exactly 2 stall cycles; StallCount=2.
REQ-037 EX_Redirect=1 together with a load-use match -> IFID_Flush=IDEX_Flush=1, PCWrite=1, no stall; FlushCount=1.
REQ-038 Rst=1 during the second stall cycle -> next cycle in RUN, PCWrite=1, both counters 0.
REQ-039 EX_Rd=0, EX_MemRead=1, ID_Rs=0 -> no stall.
REQ-040 CNT_W=2 with 5 stall cycles -> StallCount holds at 3.
